// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel registered mux: mode encodings and
// the width helper used to size channel indices.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Never returns 0, so a one-channel index still gets a 1-bit port.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from ptr, wrapping from N-1 back to 0.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    logic [SELW:0]   sum;
    logic [SELW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            // One extra bit so the wrap works when N is not a power of two.
            sum = {1'b0, ptr} + (SELW+1)'(k);
            if (sum >= (SELW+1)'(N)) begin
                sum = sum - (SELW+1)'(N);
            end
            idx = sum[SELW-1:0];
            if (!any && req[idx]) begin
                any          = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_pipe.sv
// N-channel mux with fixed-select or round-robin grant, feeding a single
// registered output slot with valid/ready handshakes on every channel.
module mux_rr_pipe
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int SELW  = clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    // Handshake: a word moves on any rising edge where valid && ready are
    // both high on the same side; valid never waits on ready, and a held
    // output word (out_valid && !out_ready) is stable until accepted.

    logic [SELW-1:0]  rr_ptr;
    logic [N-1:0]     rr_gnt;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;
    logic [N-1:0]     fix_gnt;
    logic [N-1:0]     grant;
    logic             slot_free;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic [SELW-1:0]  g_chan;

    rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    // An out-of-range sel matches no channel, so it never grants.
    always_comb begin
        fix_gnt = '0;
        for (int i = 0; i < N; i++) begin
            fix_gnt[i] = (sel == SELW'(i)) && in_valid[i];
        end
    end

    always_comb begin
        grant    = '0;
        sel_data = '0;
        g_chan   = '0;
        if (mode == MODE_RR) begin
            grant  = rr_any ? rr_gnt : '0;
            g_chan = rr_idx;
        end else begin
            grant  = fix_gnt;
            g_chan = sel;
        end
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (slot_free && !rst) ? grant : '0;
    assign xfer      = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                out_data  <= sel_data;
                out_chan  <= g_chan;
                out_valid <= 1'b1;
                if (mode == MODE_RR) begin
                    rr_ptr <= (g_chan == SELW'(N-1)) ? '0 : g_chan + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Directed plus random checks of mux_rr_pipe (N=4, WIDTH=8) against a
// cycle model with an expected-word queue.
module tb_mux_rr_pipe;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int SELW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;

    // Model state
    logic               m_valid;
    logic [WIDTH-1:0]   m_data;
    logic [SELW-1:0]    m_chan;
    logic [SELW-1:0]    m_ptr;
    logic [SELW+WIDTH-1:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    mux_rr_pipe #(.N(N), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0]    g;
        logic [SELW-1:0] idx;
        g = '0;
        if (mode == 1'b0) begin
            if (in_valid[sel]) g[sel] = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = m_ptr + SELW'(k);
                if (g == '0 && in_valid[idx]) g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    // Called just after a falling edge with inputs already driven.
    task automatic step(input string tag);
        logic [N-1:0]          er;
        logic [SELW+WIDTH-1:0] e;
        int                    gi;
        er = (rst || (m_valid && !out_ready)) ? '0 : model_grant();
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(er));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_chan  = '0;
            m_ptr   = '0;
            exp_q.delete();
        end else if (er != '0) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (er[i]) gi = i;
            exp_q.push_back({SELW'(gi), in_data[gi*WIDTH +: WIDTH]});
            m_valid = 1'b1;
            if (mode) m_ptr = (gi == N-1) ? '0 : SELW'(gi + 1);
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
        if (exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            m_chan = e[SELW+WIDTH-1:WIDTH];
            m_data = e[WIDTH-1:0];
        end
        chk({tag, " out_data"}, 32'(out_data), 32'(m_data));
        chk({tag, " out_chan"}, 32'(out_chan), 32'(m_chan));
        @(negedge clk);
    endtask

    initial begin
        m_valid   = 1'b0;
        m_data    = '0;
        m_chan    = '0;
        m_ptr     = '0;
        rst       = 1'b1;
        mode      = 1'b1;
        sel       = '0;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        @(negedge clk);

        repeat (2) step("reset");

        // Round-robin fairness: 0,1,2,3,0 back to back
        rst = 1'b0;
        repeat (5) step("rr_fair");

        // Fixed select of channel 2
        mode = 1'b0;
        sel  = 2'd2;
        step("fixed_sel2");

        // Move pointer to 3, then skip/wrap with 0101
        mode     = 1'b1;
        in_valid = 4'b0100;
        step("rr_to3");
        in_valid = 4'b0101;
        step("rr_wrap");
        step("rr_skip");

        // Backpressure on word 0x22, with a mode switch while stalled
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 4'b1111;
        step("bp_load");
        out_ready = 1'b0;
        step("bp_stall1");
        mode = 1'b1;
        step("bp_stall2");
        step("bp_stall3");
        out_ready = 1'b1;
        mode      = 1'b0;
        sel       = 2'd3;
        step("bp_release");

        // Selected channel not valid: no grant, output drains
        sel      = 2'd1;
        in_valid = 4'b1101;
        step("no_grant");
        step("idle");

        repeat (60) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom();
            step("rand");
        end

        // Reset while a word is buffered
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        step("pre_rst");
        rst = 1'b1;
        step("rst_mid");
        rst       = 1'b0;
        out_ready = 1'b1;
        step("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
